// File: rtl/keypad_scanner.sv
// ============================================================================
// Module   : keypad_scanner
// Purpose  : 4x4 matrix keypad scanner. Drives one row per scan tick, samples
//            synchronised columns, classifies each 4-row frame and debounces
//            presses and releases into a key code with a one-clock strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_scanner #(
  parameter int DEB_FRAMES = 3,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       tick_in,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [CNT_W-1:0] DEB_LIMIT = CNT_W'(DEB_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  // Column synchroniser, tick edge history and scan position
  logic [3:0]       col_meta_q;
  logic [3:0]       col_sync_q;
  logic             tick_prev_q;
  logic [1:0]       row_idx_q;
  logic [3:0]       row_n_q;

  // Frame accumulators: key count saturates at 2 (anything above is MULTI)
  logic [1:0]       acc_cnt_q;
  logic [3:0]       acc_key_q;

  // Debounce FSM and registered outputs
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       cand_q;
  logic [3:0]       key_code_q;
  logic             key_valid_q;
  logic             key_held_q;

  // Combinational helpers
  logic             tick;
  logic             frame_end;
  logic [1:0]       row_next;
  logic [3:0]       row_hits;
  logic [2:0]       row_hit_cnt;
  logic [1:0]       row_low_col;
  logic [2:0]       frame_total;
  logic [1:0]       frame_cnt_d;
  logic [3:0]       frame_key_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             deb_done;
  logic             res_none;
  logic             res_single;

  assign tick      = tick_in & ~tick_prev_q;
  assign frame_end = tick && (row_idx_q == 2'd3);
  assign row_next  = row_idx_q + 2'd1;
  assign cnt_inc   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  assign deb_done  = (cnt_inc == DEB_LIMIT);

  // Merge the current row sample into the running frame result
  always_comb begin
    row_hits    = ~col_sync_q;
    row_hit_cnt = {2'b00, row_hits[0]} + {2'b00, row_hits[1]}
                + {2'b00, row_hits[2]} + {2'b00, row_hits[3]};
    row_low_col = 2'd0;
    if (row_hits[0])      row_low_col = 2'd0;
    else if (row_hits[1]) row_low_col = 2'd1;
    else if (row_hits[2]) row_low_col = 2'd2;
    else if (row_hits[3]) row_low_col = 2'd3;
    frame_total = {1'b0, acc_cnt_q} + row_hit_cnt;
    frame_cnt_d = (frame_total >= 3'd2) ? 2'd2 : frame_total[1:0];
    // The first row that shows a press supplies the recorded key
    frame_key_d = acc_key_q;
    if ((acc_cnt_q == 2'd0) && (row_hits != 4'h0)) begin
      frame_key_d = {row_idx_q, row_low_col};
    end
    res_none   = (frame_cnt_d == 2'd0);
    res_single = (frame_cnt_d == 2'd1);
  end

  // Synchronise columns and remember the previous tick level
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      col_meta_q  <= 4'hF;
      col_sync_q  <= 4'hF;
      tick_prev_q <= 1'b1;
    end else begin
      col_meta_q  <= col_n;
      col_sync_q  <= col_meta_q;
      tick_prev_q <= tick_in;
    end
  end

  // Advance the row drive and accumulate the frame on every tick
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      row_idx_q <= 2'd0;
      row_n_q   <= 4'b1110;
      acc_cnt_q <= 2'd0;
      acc_key_q <= 4'd0;
    end else if (tick) begin
      row_idx_q <= row_next;
      row_n_q   <= ~(4'b0001 << row_next);
      if (row_idx_q == 2'd3) begin
        acc_cnt_q <= 2'd0;
        acc_key_q <= 4'd0;
      end else begin
        acc_cnt_q <= frame_cnt_d;
        acc_key_q <= frame_key_d;
      end
    end
  end

  // Debounce FSM stepped once per completed frame
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cand_q      <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (frame_end) begin
        case (state_q)
          ST_IDLE: begin
            if (res_single) begin
              cand_q <= frame_key_d;
              if (DEB_FRAMES == 1) begin
                state_q     <= ST_PRESSED;
                cnt_q       <= '0;
                key_code_q  <= frame_key_d;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
              end else begin
                state_q <= ST_DEBOUNCE;
                cnt_q   <= {{(CNT_W-1){1'b0}}, 1'b1};
              end
            end
          end
          ST_DEBOUNCE: begin
            if (res_single && (frame_key_d == cand_q)) begin
              if (deb_done) begin
                state_q     <= ST_PRESSED;
                cnt_q       <= '0;
                key_code_q  <= cand_q;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end
          end
          ST_PRESSED: begin
            // Any key activity, including a different key, keeps the hold
            if (res_none) begin
              if (DEB_FRAMES == 1) begin
                state_q    <= ST_IDLE;
                cnt_q      <= '0;
                key_held_q <= 1'b0;
              end else begin
                state_q <= ST_RELEASE;
                cnt_q   <= {{(CNT_W-1){1'b0}}, 1'b1};
              end
            end
          end
          ST_RELEASE: begin
            if (res_none) begin
              if (deb_done) begin
                state_q    <= ST_IDLE;
                cnt_q      <= '0;
                key_held_q <= 1'b0;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              state_q <= ST_PRESSED;
              cnt_q   <= '0;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign row_n     = row_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

`default_nettype wire
